// File: rtl/regdump_pkg.sv
// Shared types and constants for the register-file dump reader.
package regdump_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        HDR,
        LOAD,
        SEND,
        CSUM,
        DONE
    } state_t;

    localparam logic [7:0] HEADER_DEF   = 8'hA5;
    localparam int         NUM_REGS_DEF = 32;
    localparam int         FRAME_LEN    = 4 * NUM_REGS_DEF + 2;

    function automatic int frame_len(input int n);
        return 4 * n + 2;
    endfunction

endpackage

// File: rtl/regdump_word_ser.sv
// Holds the upper three bytes of a loaded word and steps through them
// LSB-first as the sink accepts bytes.
module regdump_word_ser (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] word_hi,
    input  logic        adv,
    output logic [7:0]  next_byte,
    output logic        last
);

    logic [23:0] sh;
    logic [1:0]  cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh  <= '0;
            cnt <= '0;
        end else if (load) begin
            sh  <= word_hi;
            cnt <= '0;
        end else if (adv) begin
            sh  <= {8'h00, sh[23:8]};
            cnt <= cnt + 2'd1;
        end
    end

    assign next_byte = sh[7:0];
    assign last      = (cnt == 2'd3);

endmodule

// File: rtl/regfile_dump_reader.sv
// Stalls the core and streams the register file as a framed byte stream:
// header, little-endian register words, then an 8-bit data checksum.
module regfile_dump_reader
    import regdump_pkg::*;
#(
    parameter int         NUM_REGS = 32,
    parameter int         ADDR_W   = 5,
    parameter logic [7:0] HEADER   = HEADER_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              stall_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [31:0]       rd_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t            state, state_n;
    logic [ADDR_W-1:0] index, index_n;
    logic [7:0]        sum, sum_n, tx_data_n;
    logic [31:0]       load_word;
    logic              xfer, ser_load, ser_adv, ser_last;
    logic [7:0]        ser_next;

    assign xfer      = tx_valid && tx_ready;
    assign rd_addr   = index;
    // x0 is hardwired zero regardless of what the read port returns
    assign load_word = (index == '0) ? 32'h0 : rd_data;
    assign stall_req = busy;

    regdump_word_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ser_load),
        .word_hi  (load_word[31:8]),
        .adv      (ser_adv),
        .next_byte(ser_next),
        .last     (ser_last)
    );

    always_comb begin
        state_n   = state;
        index_n   = index;
        sum_n     = sum;
        tx_data_n = tx_data;
        ser_load  = 1'b0;
        ser_adv   = 1'b0;
        unique case (state)
            IDLE: if (start) state_n = HALT;
            HALT: begin
                state_n   = HDR;
                tx_data_n = HEADER;
            end
            HDR: if (xfer) state_n = LOAD;
            LOAD: begin
                ser_load  = 1'b1;
                tx_data_n = load_word[7:0];
                state_n   = SEND;
            end
            SEND: if (xfer) begin
                sum_n   = sum + tx_data;
                ser_adv = 1'b1;
                if (!ser_last) begin
                    tx_data_n = ser_next;
                end else if (index != LAST_IDX) begin
                    index_n = index + 1'b1;
                    state_n = LOAD;
                end else begin
                    tx_data_n = sum + tx_data;
                    state_n   = CSUM;
                end
            end
            CSUM: if (xfer) state_n = DONE;
            DONE: begin
                state_n = IDLE;
                index_n = '0;
                sum_n   = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            index    <= '0;
            sum      <= '0;
            tx_data  <= '0;
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_n;
            index    <= index_n;
            sum      <= sum_n;
            tx_data  <= tx_data_n;
            tx_valid <= (state_n == HDR) || (state_n == SEND)
                        || (state_n == CSUM);
            busy     <= (state_n != IDLE);
            done     <= (state_n == DONE);
        end
    end

endmodule
